// File: rtl/mux_arbiter.sv
// mux_arbiter
// Round-robin arbiter that time-shares one data selector between N
// requesters. One requester at a time owns the grant. Its index is held in
// a registered select code, and its data slice is presented on out_data.
//
// Parameters
//   N        number of requesters (>= 2)
//   W        data width per requester
//   MAX_HOLD longest tenure in cycles (>= 1); enforced only when the
//            MUX_ARB_HOLD_LIMIT_EN macro is defined
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       per-requester level request
//   in_data   packed data, requester i at [i*W +: W]
//   gnt       registered one-hot grant, zero when idle
//   sel       registered owner index, keeps the last owner while idle
//   out_data  in_data slice at sel while out_valid, else 0
//   out_valid high while any grant is active (|gnt)
//
// Configuration
//   MUX_ARB_HOLD_LIMIT_EN  defined: an owner is released after MAX_HOLD
//                          consecutive cycles. Undefined: an owner keeps the
//                          grant until its req drops, and no hold counter
//                          is built.
module mux_arbiter #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         out_data,
  output logic                 out_valid
);

  localparam int SW = $clog2(N);

  if (N < 2) begin : g_bad_n
    $error("mux_arbiter: N must be >= 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("mux_arbiter: MAX_HOLD must be >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [SW-1:0] ptr;
  logic [SW-1:0] next_ptr;
  logic [SW-1:0] base;
  logic [SW-1:0] win;
  logic          any_req;
  logic          limit;
  logic          keep;

`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  assign limit = (hold_cnt == HW'(MAX_HOLD));
`else
  assign limit = 1'b0;
`endif

  // The releasing owner gets the lowest priority, so the search restarts
  // one index past it.
  assign next_ptr = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
  assign keep     = req[sel] && !limit;
  assign any_req  = |req;

  // On release the search starts from the pointer that is about to be
  // written, so the released owner is only re-selected when nobody else is
  // asking (for example, a sole requester that hit the hold limit).
  assign base = (state == GRANT) ? next_ptr : ptr;

  // First requester at or after base, wrapping modulo N. The descending
  // loop lets the nearest index overwrite the farther ones.
  // NOTE: win is given a default before the loop so that no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(base) + k) % N;
      if (req[idx]) win = SW'(idx);
    end
  end

  // NOTE: all state below uses non-blocking assignments. Each register then
  // samples the pre-edge value of every other register, and there is no
  // ordering race between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt   <= N'(1) << win;
            sel   <= win;
            state <= GRANT;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt <= HW'(1);
`endif
          end
        end
        GRANT: begin
          if (keep) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt <= hold_cnt + HW'(1);
`endif
          end else begin
            ptr <= next_ptr;
            if (any_req) begin
              // Hand over in the same edge, with no idle bubble.
              gnt <= N'(1) << win;
              sel <= win;
`ifdef MUX_ARB_HOLD_LIMIT_EN
              hold_cnt <= HW'(1);
`endif
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = |gnt;
  assign out_data  = out_valid ? in_data[sel*W +: W] : '0;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (N=4, W=16, MAX_HOLD=8).
// A cycle-level model tracks the owner, the priority pointer and the tenure
// length as plain integers. A compare process checks every DUT output
// against that model one time unit after each rising edge. Directed
// scenarios add literal expectations that pin the model down.
module tb_mux_arbiter;

  localparam int N        = 4;
  localparam int W        = 16;
  localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   gnt;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic           out_valid;

  int n_pass  = 0;
  int n_total = 0;

  mux_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: owner (-1 when idle), rotating start index, last owner,
  // and the number of cycles the current owner has held the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_ten   = 0;

  function automatic int search(input int start, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_ten   = 0;
    end else begin
      int w;
      if (m_owner < 0) begin
        w = search(m_ptr, req);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_ten   = 1;
        end
      end else if (req[m_owner] && !(HOLD_EN && m_ten == MAX_HOLD)) begin
        m_ten++;
      end else begin
        m_ptr = (m_owner + 1) % N;
        w     = search(m_ptr, req);
        if (w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_ten   = 1;
        end else begin
          m_owner = -1;
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    #1;
    eg = (m_owner >= 0) ? N'(1) << m_owner : '0;
    ed = (m_owner >= 0) ? in_data[m_owner*W +: W] : '0;
    check("cmp_gnt", 32'(gnt), 32'(eg));
    check("cmp_sel", 32'(sel), 32'(m_sel));
    check("cmp_valid", 32'(out_valid), 32'(m_owner >= 0));
    check("cmp_data", 32'(out_data), 32'(ed));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    // Reset with every request high.
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);

    // Single request.
    req   = '0;
    rst_n = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    in_data[2*W +: W] = 16'hA5A5;
    @(posedge clk); #1;
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_sel", 32'(sel), 32'h2);
    check("single_data", 32'(out_data), 32'hA5A5);
    #1 in_data[2*W +: W] = 16'h1234;
    #1 check("comb_data", 32'(out_data), 32'h1234);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_valid", 32'(out_valid), 32'h0);
    check("drop_sel_hold", 32'(sel), 32'h2);
    check("drop_data", 32'(out_data), 32'h0);

    // Round-robin handoff: two cycles per owner, then re-raise a cycle later.
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << (((c - 1) / 2) % N)));
      @(negedge clk);
      if (c % 2 == 0 && c <= 8) req[c/2 - 1] = 1'b0;
      if (c % 2 == 1 && c >= 3) req[(c - 3)/2] = 1'b1;
    end

    // Hold limit behaviour.
    do_reset();
    req = 4'b0011;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      check("hold_gnt", 32'(gnt), (c <= 8 || c == 17) ? 32'h1 : 32'h2);
    end
    @(negedge clk);
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("sole_gnt", 32'(gnt), 32'h1);
    end
`else
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check("nohold_gnt", 32'(gnt), 32'h1);
    end
`endif

    // Asynchronous reset in the middle of a tenure.
    @(negedge clk);
    req = 4'b0010;
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk); #1;
    check("mid_pre_gnt", 32'(gnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_gnt", 32'(gnt), 32'h0);
    check("mid_valid", 32'(out_valid), 32'h0);
    check("mid_sel", 32'(sel), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_post_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    req = 4'b0011;
    do_reset();
    @(posedge clk); #1;
    check("ptr_reset_gnt", 32'(gnt), 32'h1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
